arbiter_rr_registered: RTL and testbench

N-channel valid/ready arbiter with a registered output stage and selectable arbitration policy: rotating round-robin or fixed priority with an externally shiftable lowest-priority pointer. It is the next generation of the team's combinational fixed-shiftable arbiter. It adds a one-entry output register that breaks the combinational path from inputs to `out_*`. It also reports the winning channel index. It sits between N producer lanes (e.g. per-core result streams) and a single downstream consumer.

---
 rtl/arbiter_rr_registered.sv | 139 +++++++++++++
 tb/tb_arbiter_rr_registered.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_registered.sv
// arbiter_rr_registered
//   N-channel valid/ready arbiter with a one-entry registered output stage.
//   Policy: RR_MODE=1 rotating round-robin (pointer follows each winner);
//           RR_MODE=0 fixed priority, lowest-priority pointer advanced by shift.
//   Optional: define ARBITER_RR_REGISTERED_ASSERT_EN to compile in simulation
//   assertions (one-hot accept, output stability, producer hold rules,
//   INIT_LOWEST_PRIO range).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid[N]      per-channel request
//   in_data[N]       per-channel payload
//   in_ready[N]      per-channel accept (combinational, at most one high)
//   shift            advance lowest-priority pointer (RR_MODE=0 only)
//   out_valid        output register holds a beat
//   out_data         registered payload
//   out_id           index of the channel that supplied out_data
//   out_ready        downstream accept
module arbiter_rr_registered #(
  parameter int unsigned DWIDTH           = 16,
  parameter int unsigned N                = 4,
  parameter int unsigned RR_MODE          = 1,
  parameter int unsigned INIT_LOWEST_PRIO = N - 1,
  localparam int unsigned IDW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               in_valid,
  input  logic [N-1:0][DWIDTH-1:0]   in_data,
  output logic [N-1:0]               in_ready,
  input  logic                       shift,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          out_data,
  output logic [IDW-1:0]             out_id,
  input  logic                       out_ready
);

  logic [IDW-1:0]    lp_q, lp_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]    out_id_q, out_id_d;

  logic              load_c;
  logic              found_c;
  logic [IDW-1:0]    win_c;

  // (a + k) mod N, kept in IDW bits; also covers non-power-of-two N
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input int unsigned k);
    return IDW'((32'(a) + k) % N);
  endfunction

  // Search order lp+1 .. lp+N, so lp itself is checked last
  always_comb begin
    load_c  = !rst && (!out_valid_q || out_ready);
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!found_c && in_valid[wrap_add(lp_q, k)]) begin
        found_c = 1'b1;
        win_c   = wrap_add(lp_q, k);
      end
    end
  end

  // Accept strobe: only the winner, only when the output register can load
  always_comb begin
    in_ready = '0;
    if (load_c && found_c) begin
      in_ready[win_c] = 1'b1;
    end
  end

  // Next-state for output register and priority pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    lp_d        = lp_q;

    if (load_c) begin
      out_valid_d = found_c;
      if (found_c) begin
        out_data_d = in_data[win_c];
        out_id_d   = win_c;
      end
    end

    if (N == 1) begin
      lp_d = '0;
    end else if (RR_MODE != 0) begin
      if (load_c && found_c) begin
        lp_d = win_c;
      end
    end else if (shift) begin
      // the accept in this cycle already used the old pointer
      lp_d = wrap_add(lp_q, 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      lp_q        <= (N == 1) ? '0 : IDW'(INIT_LOWEST_PRIO);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      lp_q        <= lp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef ARBITER_RR_REGISTERED_ASSERT_EN
  generate
    if (INIT_LOWEST_PRIO >= N) begin : g_bad_init
      $error("INIT_LOWEST_PRIO must be below N");
    end
  endgenerate

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready))
    else $error("in_ready has more than one bit set");

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !out_ready) |=> ($stable(out_data_q) && $stable(out_id_q)))
    else $error("out_data/out_id changed under backpressure");

  for (genvar gi = 0; gi < int'(N); gi++) begin : g_in_hold
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
        (in_valid[gi] && !in_ready[gi]) |=> (in_valid[gi] && $stable(in_data[gi])))
      else $error("producer dropped in_valid or changed in_data before accept");
  end
`endif

endmodule

// File: tb/tb_arbiter_rr_registered.sv
// Self-checking bench for arbiter_rr_registered: round-robin, fixed-priority
// with shift, backpressure, sparse requests, mid-stream reset and N=1.
module tb_arbiter_rr_registered;

  localparam int unsigned DW = 16;
  localparam int unsigned NC = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    id;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // round-robin instance
  logic [NC-1:0]         rr_in_valid, rr_in_ready;
  logic [NC-1:0][DW-1:0] rr_in_data;
  logic                  rr_shift, rr_out_valid, rr_out_ready;
  logic [DW-1:0]         rr_out_data;
  logic [1:0]            rr_out_id;

  // fixed-priority instance
  logic [NC-1:0]         fp_in_valid, fp_in_ready;
  logic [NC-1:0][DW-1:0] fp_in_data;
  logic                  fp_shift, fp_out_valid, fp_out_ready;
  logic [DW-1:0]         fp_out_data;
  logic [1:0]            fp_out_id;

  // single-channel instance
  logic [0:0]            n1_in_valid, n1_in_ready;
  logic [0:0][DW-1:0]    n1_in_data;
  logic                  n1_shift, n1_out_valid, n1_out_ready;
  logic [DW-1:0]         n1_out_data;
  logic [0:0]            n1_out_id;

  int checks = 0;
  int errors = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] n1_q[$];

  arbiter_rr_registered #(.DWIDTH(DW), .N(NC), .RR_MODE(1), .INIT_LOWEST_PRIO(3)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(rr_in_valid), .in_data(rr_in_data),
    .in_ready(rr_in_ready), .shift(rr_shift), .out_valid(rr_out_valid),
    .out_data(rr_out_data), .out_id(rr_out_id), .out_ready(rr_out_ready));

  arbiter_rr_registered #(.DWIDTH(DW), .N(NC), .RR_MODE(0), .INIT_LOWEST_PRIO(3)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(fp_in_valid), .in_data(fp_in_data),
    .in_ready(fp_in_ready), .shift(fp_shift), .out_valid(fp_out_valid),
    .out_data(fp_out_data), .out_id(fp_out_id), .out_ready(fp_out_ready));

  arbiter_rr_registered #(.DWIDTH(DW), .N(1), .RR_MODE(1), .INIT_LOWEST_PRIO(0)) dut_n1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_data(n1_in_data),
    .in_ready(n1_in_ready), .shift(n1_shift), .out_valid(n1_out_valid),
    .out_data(n1_out_data), .out_id(n1_out_id), .out_ready(n1_out_ready));

  task automatic test_reset();
    rst = 1'b1;
    rr_in_valid = '1; fp_in_valid = '1; n1_in_valid = '1;
    rr_out_ready = 1'b1; fp_out_ready = 1'b1; n1_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== 19'd0) begin
      errors++;
      $display("FAIL reset_rr_out got %h exp 0", {rr_out_valid, rr_out_data, rr_out_id});
    end
    checks++;
    if ({fp_out_valid, fp_out_data, fp_out_id} !== 19'd0) begin
      errors++;
      $display("FAIL reset_fp_out got %h exp 0", {fp_out_valid, fp_out_data, fp_out_id});
    end
    checks++;
    if ({n1_out_valid, n1_out_data, n1_out_id} !== 18'd0) begin
      errors++;
      $display("FAIL reset_n1_out got %h exp 0", {n1_out_valid, n1_out_data, n1_out_id});
    end
    checks++;
    if ({rr_in_ready, fp_in_ready, n1_in_ready} !== 9'd0) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 0", {rr_in_ready, fp_in_ready, n1_in_ready});
    end
    rst = 1'b0;
    rr_in_valid = '0; fp_in_valid = '0; n1_in_valid = '0;
  endtask

  // all channels valid from reset (lp=3): ids 0,1,2,3,0,1
  task automatic test_rr_steady();
    beat_t b;
    for (int i = 0; i < int'(NC); i++) rr_in_data[i] = DW'(16'h1000 + i);
    rr_in_valid  = '1;
    rr_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back('{data: DW'(16'h1000 + (k % 4)), id: 2'(k % 4)});
    for (int k = 0; k < 6; k++) begin
      #1;
      b = exp_q[0];
      checks++;
      if (rr_in_ready !== 4'(1 << b.id)) begin
        errors++;
        $display("FAIL rr_steady_ready[%0d] got %b exp %b", k, rr_in_ready, 4'(1 << b.id));
      end
      @(posedge clk);
      #1;
      b = exp_q.pop_front();
      checks++;
      if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b1, b.data, b.id}) begin
        errors++;
        $display("FAIL rr_steady_out[%0d] got v=%b d=%h id=%0d exp d=%h id=%0d",
                 k, rr_out_valid, rr_out_data, rr_out_id, b.data, b.id);
      end
    end
  endtask

  // lp=1 on entry: lone ch2 beat, then hold it 5 cycles, then drain+refill
  task automatic test_backpressure();
    beat_t b;
    rr_in_valid   = 4'b0100;
    rr_in_data[2] = 16'hABCD;
    rr_out_ready  = 1'b1;
    exp_q.push_back('{data: 16'hABCD, id: 2'd2});
    #1;
    checks++;
    if (rr_in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_load_ready got %b exp 0100", rr_in_ready);
    end
    @(posedge clk);
    #1;
    rr_out_ready = 1'b0;
    rr_in_valid  = '1;
    for (int i = 0; i < int'(NC); i++) rr_in_data[i] = DW'(16'h2000 + i);
    for (int c = 0; c < 5; c++) begin
      b = exp_q[0];
      checks++;
      if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b1, b.data, b.id}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d exp d=%h id=%0d",
                 c, rr_out_valid, rr_out_data, rr_out_id, b.data, b.id);
      end
      #1;
      checks++;
      if (rr_in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready_low[%0d] got %b exp 0000", c, rr_in_ready);
      end
      @(posedge clk);
      #1;
    end
    void'(exp_q.pop_front());
    exp_q.push_back('{data: 16'h2003, id: 2'd3});
    rr_out_ready = 1'b1;
    #1;
    checks++;
    if (rr_in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready got %b exp 1000", rr_in_ready);
    end
    @(posedge clk);
    #1;
    b = exp_q.pop_front();
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b1, b.data, b.id}) begin
      errors++;
      $display("FAIL bp_refill got v=%b d=%h id=%0d exp d=%h id=%0d",
               rr_out_valid, rr_out_data, rr_out_id, b.data, b.id);
    end
  endtask

  // single ch1 beat, idle cycle, then all valid must pick ch2 (lp=1)
  task automatic test_sparse();
    beat_t b;
    rr_in_valid   = 4'b0010;
    rr_in_data[1] = 16'h5A5A;
    exp_q.push_back('{data: 16'h5A5A, id: 2'd1});
    #1;
    checks++;
    if (rr_in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL sparse_ready got %b exp 0010", rr_in_ready);
    end
    @(posedge clk);
    #1;
    b = exp_q.pop_front();
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b1, b.data, b.id}) begin
      errors++;
      $display("FAIL sparse_beat got v=%b d=%h id=%0d exp d=%h id=%0d",
               rr_out_valid, rr_out_data, rr_out_id, b.data, b.id);
    end
    rr_in_valid = '0;
    @(posedge clk);
    #1;
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b0, 16'h5A5A, 2'd1}) begin
      errors++;
      $display("FAIL sparse_idle got v=%b d=%h id=%0d exp v=0 d=5a5a id=1",
               rr_out_valid, rr_out_data, rr_out_id);
    end
    rr_in_valid = '1;
    exp_q.push_back('{data: 16'h2002, id: 2'd2});
    #1;
    checks++;
    if (rr_in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL sparse_lp_ready got %b exp 0100", rr_in_ready);
    end
    @(posedge clk);
    #1;
    b = exp_q.pop_front();
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b1, b.data, b.id}) begin
      errors++;
      $display("FAIL sparse_lp_beat got v=%b d=%h id=%0d exp d=%h id=%0d",
               rr_out_valid, rr_out_data, rr_out_id, b.data, b.id);
    end
  endtask

  // reset while a beat is stuck under backpressure
  task automatic test_reset_midstream();
    beat_t b;
    rr_out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rr_out_valid, rr_out_id} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL midrst_pre got v=%b id=%0d exp v=1 id=2", rr_out_valid, rr_out_id);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ready got %b exp 0000", rr_in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== 19'd0) begin
      errors++;
      $display("FAIL midrst_out got v=%b d=%h id=%0d exp 0", rr_out_valid, rr_out_data, rr_out_id);
    end
    rst = 1'b0;
    rr_out_ready = 1'b1;
    exp_q.push_back('{data: 16'h2000, id: 2'd0});
    #1;
    checks++;
    if (rr_in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_lp_ready got %b exp 0001", rr_in_ready);
    end
    @(posedge clk);
    #1;
    b = exp_q.pop_front();
    checks++;
    if ({rr_out_valid, rr_out_data, rr_out_id} !== {1'b1, b.data, b.id}) begin
      errors++;
      $display("FAIL midrst_beat got v=%b d=%h id=%0d exp d=%h id=%0d",
               rr_out_valid, rr_out_data, rr_out_id, b.data, b.id);
    end
    rr_in_valid = '0;
  endtask

  // fixed priority, all valid; shift pulses on even cycles from cycle 2
  task automatic test_fixed_shift();
    beat_t b;
    int    lp;
    int    w;
    lp = 3;
    for (int i = 0; i < int'(NC); i++) fp_in_data[i] = DW'(16'h3000 + i);
    fp_in_valid  = '1;
    fp_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      fp_shift = (c >= 2) && (c % 2 == 0);
      w = (lp + 1) % 4;
      exp_q.push_back('{data: DW'(16'h3000 + w), id: 2'(w)});
      #1;
      checks++;
      if (fp_in_ready !== 4'(1 << w)) begin
        errors++;
        $display("FAIL fp_ready[%0d] got %b exp %b", c, fp_in_ready, 4'(1 << w));
      end
      @(posedge clk);
      #1;
      b = exp_q.pop_front();
      checks++;
      if ({fp_out_valid, fp_out_data, fp_out_id} !== {1'b1, b.data, b.id}) begin
        errors++;
        $display("FAIL fp_out[%0d] got v=%b d=%h id=%0d exp d=%h id=%0d",
                 c, fp_out_valid, fp_out_data, fp_out_id, b.data, b.id);
      end
      if (fp_shift) lp = (lp + 1) % 4;
    end
    fp_shift    = 1'b0;
    fp_in_valid = '0;
  endtask

  // N=1: 8 beats with random downstream stalls, in order, no loss/dup
  task automatic test_n1_stream();
    logic [DW-1:0] beats[8];
    logic [DW-1:0] e;
    logic [DW-1:0] xd;
    logic [0:0]    xid;
    logic          acc, xfer;
    int            p, received;
    for (int k = 0; k < 8; k++) begin
      beats[k] = DW'($urandom);
      n1_q.push_back(beats[k]);
    end
    p = 0;
    received = 0;
    n1_in_valid   = 1'b1;
    n1_in_data[0] = beats[0];
    for (int cyc = 0; cyc < 300 && received < 8; cyc++) begin
      n1_out_ready = 1'($urandom_range(0, 1));
      #1;
      acc  = n1_in_valid[0] && n1_in_ready[0];
      xfer = n1_out_valid && n1_out_ready;
      xd   = n1_out_data;
      xid  = n1_out_id;
      @(posedge clk);
      #1;
      if (xfer) begin
        checks++;
        if (n1_q.size() == 0) begin
          errors++;
          $display("FAIL n1_extra_beat got d=%h exp none", xd);
        end else begin
          e = n1_q.pop_front();
          if ({xd, xid} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL n1_beat[%0d] got d=%h id=%0d exp d=%h id=0", received, xd, xid, e);
          end
        end
        received++;
      end
      if (acc) begin
        p++;
        if (p < 8) n1_in_data[0] = beats[p];
        else n1_in_valid = 1'b0;
      end
    end
    checks++;
    if (received != 8 || n1_q.size() != 0) begin
      errors++;
      $display("FAIL n1_count got %0d exp 8 (left %0d)", received, n1_q.size());
    end
    checks++;
    if (n1_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL n1_no_dup got out_valid=%b exp 0", n1_out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    rr_in_valid = '0; rr_in_data = '0; rr_shift = 1'b0; rr_out_ready = 1'b0;
    fp_in_valid = '0; fp_in_data = '0; fp_shift = 1'b0; fp_out_ready = 1'b0;
    n1_in_valid = '0; n1_in_data = '0; n1_shift = 1'b0; n1_out_ready = 1'b0;
    test_reset();
    test_rr_steady();
    test_backpressure();
    test_sparse();
    test_reset_midstream();
    test_fixed_shift();
    test_n1_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
